// File: rtl/gbfact_pkg.sv
// Shared GBFACT global-buffer defaults and types used by the buffer port logic.
package gbfact_pkg;

  localparam int unsigned GB_DEPTH_BIT = 6;
  localparam int unsigned GB_WIDTH     = 28;
  localparam int unsigned GB_NUM_RD    = 4;
  localparam int unsigned GB_RD_ID_W   = $clog2(GB_NUM_RD);

  typedef logic [GB_RD_ID_W-1:0] gb_rd_id_t;

  // Which SRAM access the port arbiter issues in a given cycle.
  typedef enum logic [1:0] {
    ACC_IDLE  = 2'd0,
    ACC_WRITE = 2'd1,
    ACC_READ  = 2'd2
  } gb_access_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr..ptr-1 with wrap and returns
// a one-hot grant plus the index just after the winner.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] next_ptr,
  output logic          any
);

  logic [IW-1:0] sel;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    any      = 1'b0;
    sel      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel = IW'((32'(ptr) + k) % N);
      if (!any && req[sel]) begin
        gnt[sel] = 1'b1;
        next_ptr = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gbfact_port_arbiter.sv
// Single-port GBFACT SRAM sharing: one fill writer and NUM_RD round-robin readers,
// one access per cycle, 1-cycle read return routed to the granted reader.
module gbfact_port_arbiter
  import gbfact_pkg::*;
#(
  parameter  int unsigned SRAM_DEPTH_BIT = GB_DEPTH_BIT,
  parameter  int unsigned SRAM_WIDTH     = GB_WIDTH,
  parameter  int unsigned NUM_RD         = GB_NUM_RD,
  parameter  int unsigned WR_BURST       = 8,
  localparam int unsigned RD_ID_W        = $clog2(NUM_RD)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_req,
  input  logic [SRAM_DEPTH_BIT-1:0]        wr_addr,
  input  logic [SRAM_WIDTH-1:0]            wr_data,
  output logic                             wr_gnt,
  input  logic [NUM_RD-1:0]                rd_req,
  input  logic [NUM_RD*SRAM_DEPTH_BIT-1:0] rd_addr,
  output logic [NUM_RD-1:0]                rd_gnt,
  output logic [NUM_RD-1:0]                rd_rvalid,
  output logic [SRAM_WIDTH-1:0]            rd_rdata,
  output logic [SRAM_DEPTH_BIT-1:0]        ram_addr_r,
  output logic [SRAM_DEPTH_BIT-1:0]        ram_addr_w,
  output logic                             ram_read_en,
  output logic                             ram_write_en,
  output logic [SRAM_WIDTH-1:0]            ram_data_in,
  input  logic [SRAM_WIDTH-1:0]            ram_data_out,
  output logic                             busy
);

  localparam int unsigned SW = $clog2(WR_BURST + 1);

  logic [SW-1:0]      wr_streak;
  logic [RD_ID_W-1:0] rr_ptr;
  logic [RD_ID_W-1:0] rr_next;
  logic [NUM_RD-1:0]  arb_gnt;
  logic               arb_any;
  logic [NUM_RD-1:0]  rvalid_q;
  gb_access_e         access;

  rr_arbiter #(.N(NUM_RD)) u_rr (
    .req      (rd_req),
    .ptr      (rr_ptr),
    .gnt      (arb_gnt),
    .next_ptr (rr_next),
    .any      (arb_any)
  );

  // Writer wins until it has taken WR_BURST grants in a row with a reader waiting.
  always_comb begin
    access = ACC_IDLE;
    if (!rst) begin
      if (wr_req && !((wr_streak == SW'(WR_BURST)) && arb_any)) begin
        access = ACC_WRITE;
      end else if (arb_any) begin
        access = ACC_READ;
      end
    end
  end

  always_comb begin
    ram_addr_r = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (arb_gnt[i]) ram_addr_r = rd_addr[i*SRAM_DEPTH_BIT +: SRAM_DEPTH_BIT];
    end
  end

  assign wr_gnt       = (access == ACC_WRITE);
  assign rd_gnt       = (access == ACC_READ) ? arb_gnt : '0;
  assign ram_write_en = wr_gnt;
  assign ram_read_en  = |rd_gnt;
  assign ram_addr_w   = wr_addr;
  assign ram_data_in  = wr_data;
  assign rd_rvalid    = rvalid_q;
  assign rd_rdata     = ram_data_out;
  assign busy         = !rst && ((|rvalid_q) || wr_req || (|rd_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_streak <= '0;
      rr_ptr    <= '0;
      rvalid_q  <= '0;
    end else begin
      rvalid_q <= rd_gnt;
      if (wr_gnt) begin
        wr_streak <= (wr_streak == SW'(WR_BURST)) ? wr_streak : wr_streak + 1'b1;
      end else begin
        wr_streak <= '0;
      end
      if (access == ACC_READ) rr_ptr <= rr_next;
    end
  end

endmodule

// File: tb/tb_gbfact_port_arbiter.sv
// Directed vector table plus hand sequences and scoreboarded random traffic
// for the GBFACT port arbiter, with a behavioural single-port SRAM wrapper.
module tb_gbfact_port_arbiter;

  localparam int unsigned DB = 6;
  localparam int unsigned W  = 28;
  localparam int unsigned N  = 4;
  localparam int unsigned WB = 8;
  // A reader can sit behind every other reader, each preceded by a full write burst.
  localparam int unsigned MAX_WAIT = N * (WB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [DB-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_gnt;
  logic [N-1:0]  rd_req = '0;
  logic [N*DB-1:0] rd_addr = '0;
  logic [N-1:0]  rd_gnt, rd_rvalid;
  logic [W-1:0]  rd_rdata;
  logic [DB-1:0] ram_addr_r, ram_addr_w;
  logic          ram_read_en, ram_write_en;
  logic [W-1:0]  ram_data_in, ram_data_out;
  logic          busy;

  int tests = 0;
  int fails = 0;

  gbfact_port_arbiter #(
    .SRAM_DEPTH_BIT (DB),
    .SRAM_WIDTH     (W),
    .NUM_RD         (N),
    .WR_BURST       (WB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_gnt       (wr_gnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_gnt       (rd_gnt),
    .rd_rvalid    (rd_rvalid),
    .rd_rdata     (rd_rdata),
    .ram_addr_r   (ram_addr_r),
    .ram_addr_w   (ram_addr_w),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out    <= mem[ram_addr_r];
  end

  typedef struct {
    logic          rst;
    logic          wr;
    logic [DB-1:0] wa;
    logic [W-1:0]  wd;
    logic [N-1:0]  rq;
    logic [N*DB-1:0] ra;
    logic          e_wg;
    logic [N-1:0]  e_rg;
    logic [N-1:0]  e_rv;
    logic [W-1:0]  e_rd;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic [DB-1:0] wa, logic [W-1:0] wd,
                              logic [N-1:0] rq, logic [N*DB-1:0] ra, logic ewg,
                              logic [N-1:0] erg, logic [N-1:0] erv, logic [W-1:0] erd);
    vec_t v;
    v.rst = r; v.wr = w; v.wa = wa; v.wd = wd; v.rq = rq; v.ra = ra;
    v.e_wg = ewg; v.e_rg = erg; v.e_rv = erv; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    rst = v.rst; wr_req = v.wr; wr_addr = v.wa; wr_data = v.wd;
    rd_req = v.rq; rd_addr = v.ra;
    @(negedge clk);
    chk({tag, ".wr_gnt"}, 64'(wr_gnt), 64'(v.e_wg));
    chk({tag, ".rd_gnt"}, 64'(rd_gnt), 64'(v.e_rg));
    chk({tag, ".rd_rvalid"}, 64'(rd_rvalid), 64'(v.e_rv));
    if (v.e_rv != '0) chk({tag, ".rd_rdata"}, 64'(rd_rdata), 64'(v.e_rd));
    chk({tag, ".both_en"}, 64'(ram_write_en & ram_read_en), 64'd0);
  endtask

  localparam logic [N*DB-1:0] RA  = {6'd13, 6'd12, 6'd11, 6'd10};
  localparam logic [N*DB-1:0] RA5 = {6'd0, 6'd5, 6'd0, 6'd0};
  localparam logic [N*DB-1:0] RA9 = {6'd0, 6'd0, 6'd0, 6'd9};
  localparam logic [N*DB-1:0] R21 = {6'd0, 6'd0, 6'd21, 6'd0};

  vec_t tbl [17];

  // random-phase state
  logic          w_req;
  logic [DB-1:0] w_addr;
  logic [W-1:0]  w_data;
  logic [N-1:0]  r_req;
  logic [DB-1:0] r_addr [N];
  logic          last_wg;
  logic [N-1:0]  last_rg;
  logic [N-1:0]  exp_rv;
  logic [W-1:0]  exp_rd;
  logic          exp_rd_ok;
  logic [W-1:0]  ref_mem [64];
  logic [63:0]   ref_ok;
  int unsigned   waits [N];
  int unsigned   max_wait;

  initial begin
    // vectors: write/read-back, then 4 preload writes, reset, full round-robin sweep
    tbl[0]  = mk(0, 1, 6'd5, 28'h0ABCDEF, 4'b0000, RA,  1, 4'b0000, 4'b0000, 28'h0);
    tbl[1]  = mk(0, 0, 6'd0, 28'h0,       4'b0100, RA5, 0, 4'b0100, 4'b0000, 28'h0);
    tbl[2]  = mk(0, 0, 6'd0, 28'h0,       4'b0000, RA,  0, 4'b0000, 4'b0100, 28'h0ABCDEF);
    for (int k = 0; k < 4; k++)
      tbl[3+k] = mk(0, 1, DB'(10 + k), W'(28'h100 + k), 4'b0000, RA, 1, 4'b0000, 4'b0000, 28'h0);
    tbl[7]  = mk(1, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b0000, 28'h0);
    tbl[8]  = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0001, 4'b0000, 28'h0);
    tbl[9]  = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0010, 4'b0001, 28'h100);
    tbl[10] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0100, 4'b0010, 28'h101);
    tbl[11] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b1000, 4'b0100, 28'h102);
    tbl[12] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0001, 4'b1000, 28'h103);
    tbl[13] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0010, 4'b0001, 28'h100);
    tbl[14] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b0100, 4'b0010, 28'h101);
    tbl[15] = mk(0, 0, 6'd0, 28'h0, 4'b1111, RA, 0, 4'b1000, 4'b0100, 28'h102);
    tbl[16] = mk(0, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b1000, 28'h103);

    // reset with requests present: grants and busy forced low
    rst = 1'b1; wr_req = 1'b1; rd_req = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.wr_gnt", 64'(wr_gnt), 64'd0);
    chk("rst.rd_gnt", 64'(rd_gnt), 64'd0);
    chk("rst.rd_rvalid", 64'(rd_rvalid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);

    for (int i = 0; i < 17; i++) begin
      apply_vec(tbl[i], $sformatf("vec%0d", i));
      if (i == 2) chk("vec2.busy_return", 64'(busy), 64'd1);
    end

    // write burst limit: 8 writes, one read for reader 1, then writes resume
    apply_vec(mk(1, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b0000, 28'h0), "burst.rst");
    for (int c = 0; c < 20; c++) begin
      apply_vec(mk(0, 1, 6'd20, W'(c), (c <= 8) ? 4'b0010 : 4'b0000, R21,
                   (c != 8), (c == 8) ? 4'b0010 : 4'b0000,
                   (c == 9) ? 4'b0010 : 4'b0000, 28'h0), $sformatf("burst%0d", c));
    end

    // grant order defines memory order on a shared address
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b0000, RA9, 0, 4'b0000, 4'b0000, 28'h0), "order.idle");
    apply_vec(mk(0, 1, 6'd9, 28'h1, 4'b0000, RA9, 1, 4'b0000, 4'b0000, 28'h0), "order.w1");
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b0001, RA9, 0, 4'b0001, 4'b0000, 28'h0), "order.r1");
    apply_vec(mk(0, 1, 6'd9, 28'h2, 4'b0000, RA9, 1, 4'b0000, 4'b0001, 28'h1), "order.w2");
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b0001, RA9, 0, 4'b0001, 4'b0000, 28'h0), "order.r2");
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b0000, RA9, 0, 4'b0000, 4'b0001, 28'h2), "order.ret2");

    // reset right after a read grant drops the return and clears rr_ptr
    apply_vec(mk(1, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b0000, 28'h0), "rstrd.rst0");
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b1000, RA, 0, 4'b1000, 4'b0000, 28'h0), "rstrd.g3");
    #1 rst = 1'b1; rd_req = '0;
    apply_vec(mk(1, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b0000, 28'h0), "rstrd.hold");
    chk("rstrd.busy", 64'(busy), 64'd0);
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b1001, RA, 0, 4'b0001, 4'b0000, 28'h0), "rstrd.g0");
    apply_vec(mk(0, 0, 6'd0, 28'h0, 4'b0000, RA, 0, 4'b0000, 4'b0001, 28'h100), "rstrd.ret0");

    // random traffic against a reference memory
    w_req = 0; w_addr = '0; w_data = '0; r_req = '0; last_wg = 0; last_rg = '0;
    exp_rv = '0; exp_rd = '0; exp_rd_ok = 0; ref_ok = '0; max_wait = 0;
    for (int i = 0; i < int'(N); i++) begin r_addr[i] = '0; waits[i] = 0; end
    for (int c = 0; c < 3060; c++) begin
      @(posedge clk); #1;
      if (last_wg) w_req = 0;
      if (!w_req && c < 3000 && $urandom_range(0, 99) < 60) begin
        w_req = 1; w_addr = DB'($urandom_range(0, 15)); w_data = W'($urandom);
      end
      for (int i = 0; i < int'(N); i++) begin
        if (last_rg[i]) r_req[i] = 0;
        if (!r_req[i] && c < 3000 && $urandom_range(0, 99) < 30) begin
          r_req[i] = 1; r_addr[i] = DB'($urandom_range(0, 15));
        end
        rd_addr[i*DB +: DB] = r_addr[i];
      end
      wr_req = w_req; wr_addr = w_addr; wr_data = w_data; rd_req = r_req;
      @(negedge clk);
      chk("rnd.rd_rvalid", 64'(rd_rvalid), 64'(exp_rv));
      if (exp_rv != '0 && exp_rd_ok) chk("rnd.rd_rdata", 64'(rd_rdata), 64'(exp_rd));
      chk("rnd.busy", 64'(busy), 64'(w_req || (|r_req) || (|exp_rv)));
      chk("rnd.exclusive", 64'((wr_gnt && (|rd_gnt)) || !$onehot0(rd_gnt)), 64'd0);
      chk("rnd.gnt_without_req", 64'((rd_gnt & ~r_req) | N'(wr_gnt & ~w_req)), 64'd0);
      chk("rnd.idle_with_req", 64'((w_req || (|r_req)) && !wr_gnt && (rd_gnt == '0)), 64'd0);
      exp_rv = rd_gnt;
      exp_rd_ok = 0;
      for (int i = 0; i < int'(N); i++) begin
        if (rd_gnt[i]) begin
          exp_rd = ref_mem[r_addr[i]]; exp_rd_ok = ref_ok[r_addr[i]];
          waits[i] = 0;
        end else if (r_req[i]) begin
          waits[i]++;
          if (waits[i] > max_wait) max_wait = waits[i];
        end
      end
      if (wr_gnt) begin ref_mem[w_addr] = w_data; ref_ok[w_addr] = 1'b1; end
      last_wg = wr_gnt; last_rg = rd_gnt;
    end
    chk("rnd.max_wait_ok", 64'(max_wait <= MAX_WAIT), 64'd1);
    chk("rnd.drained", 64'({w_req & ~last_wg, r_req & ~last_rg}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
